// File: rtl/sort_stream_ctrl.sv
// Stream loader/unloader around a 2^L-entry sorting engine: loads a frame,
// pads it with all-ones, starts the sort, then streams the first count results.
module sort_stream_ctrl #(
  parameter int N = 8,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic         s_WrInit,
  output logic         s_Rd,
  output logic [L-1:0] s_RAddr,
  output logic [N-1:0] s_DataIn,
  output logic         s_start,
  input  logic [N-1:0] s_DataOut,
  input  logic         s_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] PAD   = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] RD0   = 3'd5;
  localparam logic [2:0] RD1   = 3'd6;
  localparam logic [2:0] OUT   = 3'd7;

  localparam logic [L:0] FULL = {1'b1, {L{1'b0}}};
  localparam logic [L:0] ONE  = {{L{1'b0}}, 1'b1};

  logic [2:0] state;
  logic [L:0] wr_ptr;
  logic [L:0] count;
  logic [L:0] rd_ptr;
  logic       wait_skip;

  logic       loading;
  logic       accept;
  logic       pad_write;
  logic       last_out;
  logic [L:0] count_inc;

  // in_ready is forced low while rst is held so nothing is accepted during reset
  assign loading   = ((state == IDLE) || (state == LOAD)) && !rst;
  assign in_ready  = loading;
  assign accept    = in_valid && loading;
  assign pad_write = (state == PAD);
  assign count_inc = count + ONE;
  assign last_out  = (rd_ptr == (count - ONE));

  assign out_valid = (state == OUT);
  assign out_last  = (state == OUT) && last_out;
  assign s_start   = (state == START);
  assign busy      = !((state == IDLE) || (state == LOAD));
  assign s_WrInit  = accept || pad_write;
  assign s_Rd      = (state == RD0) || (state == RD1);

  // Sorter address/data mux; address idles at zero when the memory is not in use
  always_comb begin
    s_RAddr  = {L{1'b0}};
    s_DataIn = {N{1'b0}};
    if (accept) begin
      s_RAddr  = wr_ptr[L-1:0];
      s_DataIn = in_data;
    end else if (pad_write) begin
      s_RAddr  = wr_ptr[L-1:0];
      s_DataIn = {N{1'b1}};
    end else if (s_Rd) begin
      s_RAddr  = rd_ptr[L-1:0];
    end else begin
      s_RAddr  = {L{1'b0}};
    end
  end

  // Frame sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= {(L+1){1'b0}};
      count     <= {(L+1){1'b0}};
      rd_ptr    <= {(L+1){1'b0}};
      wait_skip <= 1'b0;
      out_data  <= {N{1'b0}};
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            wr_ptr <= wr_ptr + ONE;
            count  <= count_inc;
            if (in_last || (count_inc == FULL)) begin
              state <= (count_inc == FULL) ? START : PAD;
            end else begin
              state <= LOAD;
            end
          end
        end
        PAD: begin
          wr_ptr <= wr_ptr + ONE;
          if (wr_ptr[L-1:0] == {L{1'b1}}) begin
            state <= START;
          end
        end
        START: begin
          wait_skip <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          // s_done may still be high from the previous frame in the first WAIT cycle
          wait_skip <= 1'b0;
          if (!wait_skip && s_done) begin
            rd_ptr <= {(L+1){1'b0}};
            state  <= RD0;
          end
        end
        RD0: begin
          state <= RD1;
        end
        RD1: begin
          out_data <= s_DataOut;
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (last_out) begin
              wr_ptr <= {(L+1){1'b0}};
              count  <= {(L+1){1'b0}};
              rd_ptr <= {(L+1){1'b0}};
              state  <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + ONE;
              state  <= RD0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sort_stream_ctrl.md
# sort_stream_ctrl

Stream-side sequencer wrapped around the 2^L-entry sorting engine. It accepts one frame of up to 2^L words on a valid/ready input stream and writes them into the sorter memory, padding unused entries with all-ones. It then pulses the sorter start, waits for completion, and reads the first `count` sorted (ascending) entries back out on a valid/ready output stream. It is both the loader upstream of the sorter and the unloader downstream of it.

## Interface
- `N`, default 8: data word width; must match the sorter.
- `L`, default 4: sorter address width; frame capacity is 2^L words.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_data`  in  N  input word.
- `in_last`  in  1  marks the final word of the frame.
- `in_ready`  out  1  block accepts a word this cycle.
- `out_valid`  out  1  output word present.
- `out_data`  out  N  sorted output word.
- `out_last`  out  1  marks the final output word of the frame.
- `out_ready`  in  1  downstream accepts the output word.
- `busy`  out  1  a frame is padding, sorting or unloading.
- `s_WrInit`  out  1  sorter memory write enable.
- `s_Rd`  out  1  sorter read enable.
- `s_RAddr`  out  L  sorter memory address.
- `s_DataIn`  out  N  sorter write data.
- `s_start`  out  1  one-cycle sorter start pulse.
- `s_DataOut`  in  N  sorter read data.
- `s_done`  in  1  sorter completion level.

## Operation
- The FSM has these states: IDLE, LOAD, PAD, START, WAIT, RD0, RD1, OUT.
- Internal counters:
  - `wr_ptr` is L+1 bits.
  - `count` is L+1 bits and holds the words received, from 1 to 2^L.
  - `rd_ptr` is L+1 bits.
- IDLE and LOAD:
  - `in_ready`=1.
  - On a handshake, `s_WrInit`=1, `s_RAddr`=`wr_ptr[L-1:0]` and `s_DataIn`=`in_data`, combinationally in the same cycle. Then `wr_ptr`++ and `count`++.
  - IDLE goes to LOAD on the first accepted word.
  - The frame ends on the accepted word with `in_last`=1, or on the 2^L-th accepted word regardless of `in_last`.
  - At frame end, go to PAD if `count`<2^L, otherwise go to START.
- PAD:
  - `in_ready`=0.
  - Each cycle, write all-ones to address `wr_ptr` and increment `wr_ptr`.
  - After writing address 2^L-1, go to START.
- START: `s_start`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - `s_done` is ignored in the cycle immediately after START.
  - After that, the first cycle with `s_done`=1 moves to RD0 with `rd_ptr`=0.
- RD0: `s_Rd`=1 and `s_RAddr`=`rd_ptr`.
- RD1:
  - `s_Rd`=1 and the same `s_RAddr` as RD0.
  - At the end of the cycle, `s_DataOut` is captured into `out_data`, which tolerates 0- or 1-cycle sorter read latency.
  - Then go to OUT.
- OUT:
  - `out_valid`=1.
  - `out_last`=1 when `rd_ptr`==`count`-1.
  - `out_data` and `out_last` stay stable until `out_ready`.
  - On handshake: if this is the last word, clear the counters and go to IDLE; otherwise `rd_ptr`++ and go to RD0.
- `s_WrInit` and `s_Rd` are never high together.
- `s_RAddr` is 0 whenever neither `s_WrInit` nor `s_Rd` is asserted.
- `busy`=1 in PAD through OUT, and 0 in IDLE and LOAD.
- Data words equal to all-ones are legal. Such a word ties with the pad words, so the first `count` outputs are still correct.

## Timing
- Reset, asynchronous:
  - State goes to IDLE and all counters to 0.
  - `out_data` is 0.
  - All outputs are 0 while `rst`=1, including `in_ready`.
  - `in_ready` becomes 1 in the first cycle after `rst` deasserts.
- Input throughput is one word per cycle.
- Padding takes 2^L−`count` cycles.
- The `s_start` pulse follows the last write by exactly one cycle.
- Output throughput is at most one word per 3 cycles (RD0, RD1, OUT).
- The first `out_valid` appears 3 cycles after the cycle in which `s_done` is sampled high.
- Reset during any state aborts the frame immediately:
  - `out_valid` drops and the partial frame is discarded.
  - The sorter shares `rst` and is not separately handled.
- `in_valid` gaps in LOAD only stall loading. There is no timeout.
- Upstream words offered while `busy` are not accepted (`in_ready`=0).

## Test plan
- Full frame: 16 words `0F,0E,…,00` back-to-back, no `in_last`.
  - Required: no PAD cycles, and `s_start` one cycle after the 16th write.
  - Required: outputs `00..0F` in order, with `out_last` only on `0F`.
- Short frame: `7,3,9,1,5`, with `in_last` on `5`.
  - Required: 11 pad writes of `FF` to addresses 5..15.
  - Required: outputs `1,3,5,7,9`, with `out_last` on `9`, then `in_ready`=1.
- Backpressure on a 3-word frame `2,1,FF`:
  - Hold `out_ready`=0 for 5 cycles on each word.
  - Required: `out_data` and `out_last` stable while stalled, and outputs `1,2,FF`.
- Single word `AA` with `in_last`:
  - Required: 15 pad writes.
  - Required: one output `AA` with `out_last`=1.
- Reset asserted in WAIT, then a new 2-word frame `4,2`:
  - Required: all outputs 0 during reset.
  - Required: no stale output after reset, and outputs `2,4`.
- `in_valid` toggling every other cycle during LOAD of 4 words:
  - Required: exactly 4 writes to addresses 0..3, and correct sorted output.
